// File: rtl/fir_out_decimator.sv
// Purpose: decimate the FIR output stream, round/saturate to OUT_W, and queue results for a valid/ready consumer.
// Latency: a kept sample is in the stage register after edge k and at the FIFO head (out_valid=1) after edge k+1.
// Backpressure: none upstream; a kept sample arriving at a full FIFO with no pop is dropped and flagged in ovf.
module fir_out_decimator #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int DECIM = 4,
    parameter int SHIFT = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [IN_W-1:0]     in_data,
    input  logic                       in_valid,
    output logic signed [OUT_W-1:0]    out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       sat,
    output logic                       ovf,
    input  logic                       clr_status
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int SW = IN_W + 1;

    // Rounding constant is half an LSB of the shifted result; zero when there is no shift.
    localparam logic signed [SW-1:0] RND_C = SW'((1 << SHIFT) >> 1);
    localparam logic signed [SW-1:0] SMAX  = SW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN  = ~SMAX;
    localparam logic [OUT_W-1:0]     OMAX  = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0]     OMIN  = {1'b1, {(OUT_W - 1){1'b0}}};

    logic [PW-1:0]          phase;
    logic                   keep;
    logic signed [SW-1:0]   ext;
    logic signed [SW-1:0]   rnd;
    logic signed [SW-1:0]   scl;
    logic                   clip_hi;
    logic                   clip_lo;
    logic [OUT_W-1:0]       sat_val;

    logic                   stg_vld;
    logic [OUT_W-1:0]       stg_dat;

    logic [OUT_W-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;

    assign keep = in_valid && (phase == '0);

    // Round half toward +inf at IN_W+1 bits, then clamp into the signed OUT_W range.
    always_comb begin
        ext     = {in_data[IN_W-1], in_data};
        rnd     = ext + RND_C;
        scl     = rnd >>> SHIFT;
        clip_hi = (scl > SMAX);
        clip_lo = (scl < SMIN);
        sat_val = scl[OUT_W-1:0];
        if (clip_hi) begin
            sat_val = OMAX;
        end else if (clip_lo) begin
            sat_val = OMIN;
        end
    end

    // Phase counter, stage register and sticky saturation flag (a new clip beats a clear).
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase   <= '0;
            stg_vld <= 1'b0;
            stg_dat <= '0;
            sat     <= 1'b0;
        end else begin
            if (in_valid) begin
                phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
            end
            stg_vld <= keep;
            if (keep) begin
                stg_dat <= sat_val;
            end
            sat <= (keep & (clip_hi | clip_lo)) | (sat & ~clr_status);
        end
    end

    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts the stage value when the head leaves in the same cycle.
    assign push      = stg_vld & (~full | pop);
    assign drop      = stg_vld & full & ~pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // FIFO storage; contents need no reset because out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= stg_dat;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag (a new drop beats a clear).
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            ovf <= drop | (ovf & ~clr_status);
        end
    end

endmodule

// File: tb/tb_fir_out_decimator.sv
// Purpose: randomized and directed check of fir_out_decimator against a queue-based reference model.
// Latency: two instances (DECIM=4 and DECIM=1) share stimulus; outputs compared 1 time unit after each edge.
// Backpressure: out_ready is driven directly by the bench, both held low and randomized.
module tb_fir_out_decimator;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int SHIFT = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset;
    logic signed [IN_W-1:0]   in_data;
    logic                     in_valid;
    logic                     out_ready;
    logic                     clr_status;

    logic signed [OUT_W-1:0]  od4, od1;
    logic                     ov4, ov1;
    logic [2:0]               cnt4, cnt1;
    logic                     sat4, sat1, ovf4, ovf1;

    fir_out_decimator #(.IN_W(IN_W), .OUT_W(OUT_W), .DECIM(4), .SHIFT(SHIFT), .DEPTH(DEPTH)) u_d4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .out_data(od4), .out_valid(ov4), .out_ready(out_ready), .count(cnt4),
        .sat(sat4), .ovf(ovf4), .clr_status(clr_status)
    );

    fir_out_decimator #(.IN_W(IN_W), .OUT_W(OUT_W), .DECIM(1), .SHIFT(SHIFT), .DEPTH(DEPTH)) u_d1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .count(cnt1),
        .sat(sat1), .ovf(ovf1), .clr_status(clr_status)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state, index 0 = DECIM 4, index 1 = DECIM 1.
    int q [2][$];
    bit m_stg [2];
    int m_stg_v [2];
    bit m_sat [2];
    bit m_ovf [2];
    int m_nval [2];

    // Values the consumer accepted, logged per instance.
    int popped4 [$];
    int popped1 [$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Round-half-up division by 2^SHIFT using plain integer arithmetic with floor semantics.
    function automatic int scale(input int x);
        int d, t;
        d = 1 << SHIFT;
        t = x + d / 2;
        if (t >= 0) return t / d;
        return -((-t + d - 1) / d);
    endfunction

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            int dec, r;
            bit keep, clip, drop;
            dec = (m == 0) ? 4 : 1;
            if (!reset) begin
                q[m].delete();
                m_stg[m]  = 1'b0;
                m_sat[m]  = 1'b0;
                m_ovf[m]  = 1'b0;
                m_nval[m] = 0;
            end else begin
                drop = 1'b0;
                if (q[m].size() > 0 && out_ready) void'(q[m].pop_front());
                if (m_stg[m]) begin
                    if (q[m].size() < DEPTH) q[m].push_back(m_stg_v[m]);
                    else drop = 1'b1;
                end
                m_ovf[m] = drop | (m_ovf[m] & !clr_status);
                keep = in_valid && (m_nval[m] % dec == 0);
                if (in_valid) m_nval[m]++;
                r = scale(int'(in_data));
                clip = (r > 127) || (r < -128);
                m_stg[m]   = keep;
                m_stg_v[m] = (r > 127) ? 127 : (r < -128) ? -128 : r;
                m_sat[m]   = (keep && clip) | (m_sat[m] & !clr_status);
            end
        end
    endtask

    task automatic check_all();
        chk("vld4", int'(ov4), int'(q[0].size() > 0));
        chk("cnt4", int'(cnt4), q[0].size());
        if (q[0].size() > 0) chk("dat4", int'(od4), q[0][0]);
        chk("sat4", int'(sat4), int'(m_sat[0]));
        chk("ovf4", int'(ovf4), int'(m_ovf[0]));
        chk("vld1", int'(ov1), int'(q[1].size() > 0));
        chk("cnt1", int'(cnt1), q[1].size());
        if (q[1].size() > 0) chk("dat1", int'(od1), q[1][0]);
        chk("sat1", int'(sat1), int'(m_sat[1]));
        chk("ovf1", int'(ovf1), int'(m_ovf[1]));
    endtask

    task automatic cycle();
        if (ov4 && out_ready) popped4.push_back(int'(od4));
        if (ov1 && out_ready) popped1.push_back(int'(od1));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic step(input bit v, input int d);
        in_valid = v;
        in_data  = IN_W'(d);
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        clr_status = 1'b0;
        cycle();
        reset = 1'b1;
        popped4.delete();
        popped1.delete();
    endtask

    initial begin
        reset = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clr_status = 1'b0;
        cycle();
        cycle();
        chk("rst_dat4", int'(od4), 0);
        chk("rst_vld1", int'(ov1), 0);
        chk("rst_cnt1", int'(cnt1), 0);
        reset = 1'b1;

        // Constant 160 stream, DECIM 4: four outputs of 10, first visible two edges after first sample.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 160);
            if (i == 0) chk("lat_e1", int'(ov4), 0);
            if (i == 1) chk("lat_e2", int'(ov4), 1);
        end
        step(1'b0, 0);
        step(1'b0, 0);
        step(1'b0, 0);
        chk("n_out160", popped4.size(), 4);
        foreach (popped4[i]) chk("val160", popped4[i], 10);
        chk("sat160", int'(sat4), 0);

        // Rounding ties and near-ties.
        do_reset();
        step(1'b1, 24); step(1'b1, 23); step(1'b1, -24); step(1'b1, -25);
        repeat (4) step(1'b0, 0);
        chk("rnd_n", popped1.size(), 4);
        if (popped1.size() == 4) begin
            chk("rnd0", popped1[0], 2);  chk("rnd1", popped1[1], 1);
            chk("rnd2", popped1[2], -1); chk("rnd3", popped1[3], -2);
        end

        // Saturation, clear, and clear coincident with a new clip.
        step(1'b1, 4000); step(1'b1, -4000); step(1'b0, 0);
        chk("sat_set", int'(sat1), 1);
        clr_status = 1'b1; step(1'b0, 0); clr_status = 1'b0;
        chk("sat_clr", int'(sat1), 0);
        clr_status = 1'b1; step(1'b1, 4000); clr_status = 1'b0;
        chk("sat_win", int'(sat1), 1);
        repeat (3) step(1'b0, 0);
        chk("sat_hi", popped1[popped1.size() - 3], 127);
        chk("sat_lo", popped1[popped1.size() - 2], -128);

        // Overflow: fifth sample dropped while the consumer stalls.
        do_reset();
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) step(1'b1, 16 * v);
        step(1'b0, 0);
        chk("ovf_cnt", int'(cnt1), 4);
        chk("ovf_flag", int'(ovf1), 1);
        out_ready = 1'b1;
        repeat (6) step(1'b0, 0);
        chk("ovf_n", popped1.size(), 4);
        foreach (popped1[i]) chk("ovf_val", popped1[i], i + 1);

        // Full FIFO with simultaneous push and pop every cycle.
        do_reset();
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) step(1'b1, 16 * v);
        out_ready = 1'b1;
        for (int v = 6; v <= 12; v++) begin
            step(1'b1, 16 * v);
            chk("full_cnt", int'(cnt1), 4);
            chk("full_ovf", int'(ovf1), 0);
        end
        repeat (6) step(1'b0, 0);
        chk("full_n", popped1.size(), 12);
        foreach (popped1[i]) chk("full_ord", popped1[i], i + 1);

        // Reset with three entries queued flushes everything and restarts the phase.
        do_reset();
        out_ready = 1'b0;
        step(1'b1, 16); step(1'b1, 32); step(1'b1, 48); step(1'b0, 0);
        chk("pre_cnt", int'(cnt1), 3);
        reset = 1'b0; step(1'b0, 0); reset = 1'b1;
        chk("flush_cnt", int'(cnt1), 0);
        chk("flush_vld", int'(ov1), 0);
        step(1'b1, 160); step(1'b1, 160);
        chk("restart_vld4", int'(ov4), 1);
        chk("restart_dat4", int'(od4), 10);

        // Randomized traffic checked every cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            int d;
            reset      = ($urandom_range(0, 199) != 0);
            clr_status = ($urandom_range(0, 15) == 0);
            out_ready  = ($urandom_range(0, 3) != 0) ^ (i % 200 < 40);
            if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, 65535)) - 32768;
            else d = int'($urandom_range(0, 5000)) - 2500;
            step($urandom_range(0, 4) != 0, d);
        end
        reset = 1'b1;
        clr_status = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
